// File: rtl/pkg_demux.sv
// Shared definitions for the 1-to-4 demultiplexer: channel count, selector type
// and the per-channel occupancy state.
package pkg_demux;

    localparam int NUM_CANALES = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

endpackage

// File: rtl/module_canal_salida.sv
// One output channel of the demux: a one-entry holding register with an
// empty/full state and an 8-bit wrap-around delivery counter.
module module_canal_salida
    import pkg_demux::*;
#(
    parameter int ANCHO = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [ANCHO-1:0] data_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [ANCHO-1:0] out_data_o,
    output logic [7:0]       out_cnt_o
);

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] dato_q,   dato_d;
    logic [7:0]       cnt_q,    cnt_d;
    logic             out_hs_s;

    // Next-state: a load always wins, so a same-cycle drain and refill stays full.
    always_comb begin
        estado_d = estado_q;
        dato_d   = dato_q;
        cnt_d    = cnt_q;
        out_hs_s = 1'b0;
        if ((estado_q == LLENO) && (out_ready_i == 1'b1)) begin
            out_hs_s = 1'b1;
        end else begin
            out_hs_s = 1'b0;
        end
        if (load_i == 1'b1) begin
            estado_d = LLENO;
            dato_d   = data_i;
        end else if (out_hs_s == 1'b1) begin
            estado_d = VACIO;
        end else begin
            estado_d = estado_q;
        end
        if (out_hs_s == 1'b1) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Channel state, held word and delivery counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= VACIO;
            dato_q   <= {ANCHO{1'b0}};
            cnt_q    <= 8'd0;
        end else begin
            estado_q <= estado_d;
            dato_q   <= dato_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid_o = (estado_q == LLENO);
    assign out_data_o  = dato_q;
    assign out_cnt_o   = cnt_q;

endmodule

// File: rtl/module_demux_1_4.sv
// 1-to-4 demultiplexer with valid/ready handshakes; routes each accepted word
// into the one-entry register of the selected output channel.
module module_demux_1_4
    import pkg_demux::*;
#(
    parameter int ANCHO = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ANCHO-1:0]             in_data,
    input  logic [1:0]                   in_sel,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NUM_CANALES*ANCHO-1:0] out_data,
    output logic [NUM_CANALES-1:0]       out_valid,
    input  logic [NUM_CANALES-1:0]       out_ready,
    output logic [NUM_CANALES*8-1:0]     out_cnt
);

    logic [NUM_CANALES-1:0] sel_oh_s;
    logic [NUM_CANALES-1:0] load_s;
    sel_t                   sel_s;

    assign sel_s = in_sel;

    // Ready looks only at the selected channel, never at in_valid.
    always_comb begin
        in_ready = 1'b0;
        if ((out_valid[sel_s] == 1'b0) || (out_ready[sel_s] == 1'b1)) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Selector decode to a one-hot channel mask.
    always_comb begin
        sel_oh_s = 4'b0000;
        case (sel_s)
            2'd0:    sel_oh_s = 4'b0001;
            2'd1:    sel_oh_s = 4'b0010;
            2'd2:    sel_oh_s = 4'b0100;
            2'd3:    sel_oh_s = 4'b1000;
            default: sel_oh_s = 4'b0000;
        endcase
    end

    assign load_s = sel_oh_s & {NUM_CANALES{in_valid & in_ready}};

    for (genvar k = 0; k < NUM_CANALES; k++) begin : g_canal
        module_canal_salida #(
            .ANCHO(ANCHO)
        ) u_canal (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (load_s[k]),
            .data_i      (in_data),
            .out_ready_i (out_ready[k]),
            .out_valid_o (out_valid[k]),
            .out_data_o  (out_data[k*ANCHO +: ANCHO]),
            .out_cnt_o   (out_cnt[k*8 +: 8])
        );
    end

endmodule

// File: tb/tb_module_demux_1_4.sv
// Self-checking bench for module_demux_1_4: a per-channel scoreboard of expected
// words plus modelled delivery counters, checked by one task per scenario.
module tb_module_demux_1_4;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [4][$];
    logic [7:0] model_cnt [4];

    module_demux_1_4 #(.ANCHO(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cnt   (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_ready();
        return (exp_q[in_sel].size() == 0) || out_ready[in_sel];
    endfunction

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (exp_q[k].size() != 0);
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            model_cnt[k] = 8'd0;
        end
    endtask

    // Advance one clock edge, updating the scoreboard from the bench's own model.
    task automatic step();
        logic [3:0] ohs;
        logic       ihs;
        for (int k = 0; k < 4; k++) ohs[k] = (exp_q[k].size() != 0) && out_ready[k];
        ihs = in_valid && model_ready();
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (ohs[k]) begin
                void'(exp_q[k].pop_front());
                model_cnt[k] = model_cnt[k] + 8'd1;
            end
        end
        if (ihs) exp_q[in_sel].push_back(in_data);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hC3; out_ready = 4'b0000;
        model_clear();
        #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got=%b exp=%b", out_valid, 4'b0000); end
        checks++; if (out_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%h exp=%h", out_cnt, 32'd0); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%h exp=%h", out_data, 32'd0); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=%b", in_ready, 1'b1); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_release_valid got=%b exp=%b", out_valid, 4'b0000); end
    endtask

    task automatic test_route();
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            in_sel = 2'(k); in_data = 8'(8'h11 * (k + 1)); in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready ch=%0d got=%b exp=%b", k, in_ready, 1'b1); end
            step();
            checks++; if (out_valid[k] !== 1'b1) begin errors++; $display("FAIL route_latency ch=%0d got=%b exp=%b", k, out_valid[k], 1'b1); end
        end
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL route_valid got=%b exp=%b", out_valid, 4'b1111); end
        checks++; if (out_data !== 32'h44332211) begin errors++; $display("FAIL route_data got=%h exp=%h", out_data, 32'h44332211); end
        for (int k = 0; k < 4; k++) begin
            for (int v = 0; v < 2; v++) begin
                in_sel = 2'(k); in_valid = v[0];
                #1;
                checks++; if (in_ready !== model_ready()) begin errors++; $display("FAIL route_full_ready sel=%0d valid=%0d got=%b exp=%b", k, v, in_ready, model_ready()); end
            end
        end
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 32'h44332211) begin errors++; $display("FAIL route_hold got=%h exp=%h", out_data, 32'h44332211); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] c2;
        out_ready = 4'b0100; in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
        step();
        checks++; if (out_data[23:16] !== 8'hA5) begin errors++; $display("FAIL sim_load_a5 got=%h exp=%h", out_data[23:16], 8'hA5); end
        c2 = model_cnt[2];
        in_data = 8'h5A;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sim_ready got=%b exp=%b", in_ready, 1'b1); end
        step();
        in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        checks++; if (out_valid[2] !== 1'b1) begin errors++; $display("FAIL sim_valid got=%b exp=%b", out_valid[2], 1'b1); end
        checks++; if (out_data[23:16] !== 8'h5A) begin errors++; $display("FAIL sim_data got=%h exp=%h", out_data[23:16], 8'h5A); end
        checks++; if (out_cnt[23:16] !== 8'(c2 + 8'd1)) begin errors++; $display("FAIL sim_cnt got=%0d exp=%0d", out_cnt[23:16], c2 + 8'd1); end
        checks++; if (out_data[31:24] !== 8'h44 || out_data[15:0] !== 16'h2211) begin errors++; $display("FAIL sim_others got=%h exp=%h", out_data, 32'h445A2211); end
    endtask

    task automatic test_backpressure();
        out_ready = 4'b0010; in_sel = 2'd1; in_data = 8'h7E; in_valid = 1'b1;
        step();
        out_ready = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            in_sel = 2'd1; in_data = 8'(8'hF0 + i); in_valid = 1'b1;
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", i, in_ready, 1'b0); end
            checks++; if (out_data[15:8] !== 8'h7E || out_valid[1] !== 1'b1) begin errors++; $display("FAIL bp_data cyc=%0d got=%h/%b exp=%h/1", i, out_data[15:8], out_valid[1], 8'h7E); end
            step();
        end
        in_valid = 1'b0;
        checks++; if (out_data[15:8] !== exp_q[1][0]) begin errors++; $display("FAIL bp_scoreboard got=%h exp=%h", out_data[15:8], exp_q[1][0]); end
    endtask

    task automatic test_wrap();
        logic [7:0] c0, c1, c2;
        c0 = model_cnt[0]; c1 = model_cnt[1]; c2 = model_cnt[2];
        out_ready = 4'b1000; in_sel = 2'd3; in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i ^ 8'h3C);
            #1;
            if (out_valid[3] !== 1'b1 || out_data[31:24] !== exp_q[3][0]) begin
                checks++; errors++;
                $display("FAIL wrap_data beat=%0d got=%h exp=%h", i, out_data[31:24], exp_q[3][0]);
            end else begin
                checks++;
            end
            step();
        end
        in_valid = 1'b0; out_ready = 4'b0000;
        #1;
        checks++; if (out_cnt[31:24] !== 8'd0) begin errors++; $display("FAIL wrap_cnt3 got=%0d exp=%0d", out_cnt[31:24], 8'd0); end
        checks++; if (out_cnt[23:0] !== {c2, c1, c0}) begin errors++; $display("FAIL wrap_others got=%h exp=%h", out_cnt[23:0], {c2, c1, c0}); end
        checks++; if (out_valid !== model_valid()) begin errors++; $display("FAIL wrap_valid got=%b exp=%b", out_valid, model_valid()); end
    endtask

    task automatic test_reset_mid();
        checks++; if (out_valid !== 4'b1111) begin errors++; $display("FAIL midrst_pre_valid got=%b exp=%b", out_valid, 4'b1111); end
        in_sel = 2'd0; in_valid = 1'b1; out_ready = 4'b1111; in_data = 8'h99;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL midrst_valid got=%b exp=%b", out_valid, 4'b0000); end
        checks++; if (out_cnt !== 32'd0) begin errors++; $display("FAIL midrst_cnt got=%h exp=%h", out_cnt, 32'd0); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=%b", in_ready, 1'b1); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 4'b0000;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            in_sel = 2'(3 - k); in_data = 8'($urandom_range(0, 255)); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_data[k*8 +: 8] !== exp_q[k][0]) begin errors++; $display("FAIL b2b_data ch=%0d got=%h exp=%h", k, out_data[k*8 +: 8], exp_q[k][0]); end
        end
        out_ready = 4'b1111;
        step();
        out_ready = 4'b0000;
        #1;
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL b2b_drain got=%b exp=%b", out_valid, 4'b0000); end
        checks++; if (out_cnt !== {model_cnt[3], model_cnt[2], model_cnt[1], model_cnt[0]}) begin
            errors++; $display("FAIL b2b_cnt got=%h exp=%h", out_cnt, {model_cnt[3], model_cnt[2], model_cnt[1], model_cnt[0]});
        end
        step();
        checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL idle_valid got=%b exp=%b", out_valid, 4'b0000); end
    endtask

    initial begin
        rst_n = 1'b0; in_data = 8'h00; in_sel = 2'd0; in_valid = 1'b0; out_ready = 4'b0000;
        @(posedge clk); #1;
        test_reset();
        test_route();
        test_simultaneous();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/module_demux_1_4.md
MODULE_DEMUX_1_4 -- requirements
Module: module_demux_1_4

Interface
REQ-001 Parameter: ANCHO, default 8, data word width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_data  input  ANCHO  word to route.
REQ-005 Port: in_sel  input  2  destination channel index 0..3.
REQ-006 Port: in_valid  input  1  in_data/in_sel valid this cycle.
REQ-007 Port: in_ready  output  1  block accepts the input word this cycle.
REQ-008 Port: out_data  output  4 x ANCHO  per-channel held word.
REQ-009 Port: out_valid  output  4  per-channel word available.
REQ-010 Port: out_ready  input  4  per-channel consumer accepts.
REQ-011 Port: out_cnt  output  4 x 8  per-channel count of delivered words.

Function
REQ-012 Input handshake completes when in_valid and in_ready are both 1 at a rising clk edge; output handshake k completes when out_valid[k] and out_ready[k] are both 1.
REQ-013 Each channel k SHALL hold a one-entry register with states VACIO (empty) and LLENO (full); out_valid[k] SHALL be 1 exactly in LLENO.
REQ-014 in_ready SHALL be combinational: 1 when channel in_sel is VACIO, or when it is LLENO and out_ready[in_sel] is 1; otherwise 0.
REQ-015 in_ready SHALL depend only on in_sel, the channel states and out_ready, never on in_valid.
REQ-016 On an input handshake, channel in_sel SHALL load in_data and be LLENO on the next cycle. Latency from input handshake to out_valid is 1 cycle.
REQ-017 Channels other than in_sel SHALL not change their data on an input handshake.
REQ-018 Transition VACIO->LLENO occurs on input handshake only.
REQ-019 Transition LLENO->VACIO occurs on output handshake with no input handshake to the same channel.
REQ-020 Output and input handshake on the same channel in the same cycle SHALL keep the channel LLENO and load the new word; no bubble.
REQ-021 Output handshakes on several channels in one cycle SHALL all complete independently.
REQ-022 out_data[k] SHALL be stable while out_valid[k]=1 and out_ready[k]=0.
REQ-023 out_data[k] is don't-care in VACIO but SHALL retain its last value (no clearing).
REQ-024 out_cnt[k] SHALL increment by 1 on each output handshake of channel k and wrap 255->0.
REQ-025 in_valid=0 SHALL leave all state unchanged except output handshakes.

Reset
REQ-026 rst_n=0 SHALL asynchronously force all channels VACIO, out_valid=4'b0000, out_data=0, out_cnt=0.
REQ-027 Reset mid-operation SHALL discard held words without completing any handshake; in_ready reflects the VACIO state immediately (1).
REQ-028 Release of rst_n is synchronised externally; the first state update occurs on the first rising edge with rst_n=1.

Structure
REQ-029 Package pkg_demux SHALL hold NUM_CANALES=4, typedef for the 2-bit selector, and the enum {VACIO, LLENO}.
REQ-030 One sub-module module_canal_salida (one-entry register, state, 8-bit counter) SHALL be instantiated NUM_CANALES times; the top holds routing and in_ready logic only.

Verification
REQ-031 Reset with in_valid=1: rst_n=0 -> out_valid=0000, out_cnt all 0, in_ready=1.
REQ-032 Route in_sel=0..3, in_data=8'h11,8'h22,8'h33,8'h44, out_ready=0000 -> one cycle later out_valid=1111, out_data={44,33,22,11}, then in_ready=0 for any in_sel.
REQ-033 Channel 2 LLENO with 8'hA5, out_ready[2]=1, in_sel=2, in_data=8'h5A in the same cycle -> out_valid[2] stays 1, out_data[2]=8'h5A next cycle, out_cnt[2]+1.
REQ-034 Backpressure: channel 1 LLENO with 8'h7E, out_ready[1]=0 for 5 cycles, in_sel=1 -> in_ready=0, out_data[1]=8'h7E throughout.
REQ-035 Wrap: 256 delivered words on channel 3 -> out_cnt[3]=0, other counters unchanged.
REQ-036 Assert rst_n=0 mid-stream with all channels LLENO -> out_valid=0000 before the next clk edge, out_cnt all 0.
